// File: rtl/pcie_msi_sched_pkg.sv
// Shared types and helpers for the MSI scheduler: FSM states, grant struct,
// counter width and the multiple-message fold mask.
package pcie_msi_sched_pkg;
  localparam int CNT_W = 16;
  localparam int IDX_W = 5;
  localparam int MSI_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } arb_gnt_t;

  // mmenable[2:0] is log2 of the granted vector count, capped at 32 vectors
  function automatic logic [IDX_W-1:0] fold_mask(input logic [2:0] mm);
    logic [2:0] m;
    m = (mm > 3'd5) ? 3'd5 : mm;
    return IDX_W'((6'd1 << m) - 6'd1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/pcie_msi_rr_arb.sv
// Combinational round-robin select: lowest set request at or above ptr,
// wrapping to the lowest set request overall.
module pcie_msi_rr_arb
  import pcie_msi_sched_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output arb_gnt_t         gnt
);
  logic [IDX_W-1:0] hi_idx, lo_idx;
  logic             hi_vld, lo_vld;

  // Walk downward so the last hit written is the lowest index.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        lo_vld = 1'b1;
        if (IDX_W'(i) >= ptr) begin
          hi_idx = IDX_W'(i);
          hi_vld = 1'b1;
        end
      end
    end
    gnt.vld = lo_vld;
    gnt.idx = hi_vld ? hi_idx : lo_idx;
  end
endmodule

// File: rtl/pcie_msi_scheduler.sv
// Latches per-vector interrupt requests and issues them one at a time,
// round-robin, on the PCIe hard block's MSI interface with retry on fail/timeout.
module pcie_msi_scheduler
  import pcie_msi_sched_pkg::*;
#(
  parameter int IRQ_COUNT      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_COUNT-1:0] irq_req,
  output logic [IRQ_COUNT-1:0] irq_pending,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  output logic [31:0]          cfg_interrupt_msi_int,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [3:0]           cfg_interrupt_msi_function_number,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [CNT_W-1:0]     stat_sent,
  output logic [CNT_W-1:0]     stat_fail,
  output logic [CNT_W-1:0]     stat_timeout
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        TO_LAST  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]        BO_LAST  = CW'(BACKOFF_CYCLES);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(IRQ_COUNT - 1);
  localparam logic [IRQ_COUNT-1:0] REQ_ONE  = IRQ_COUNT'(1);
  localparam logic [MSI_W-1:0]     MSI_ONE  = MSI_W'(1);

  state_e                 state_q, state_d;
  logic [IRQ_COUNT-1:0]   pending_q, pending_d;
  logic                   pend_de_q, pend_de_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MSI_W-1:0]       msi_int_q, msi_int_d;
  logic [CNT_W-1:0]       sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
  logic [IRQ_COUNT-1:0]   clr, requeue;
  arb_gnt_t               gnt;

  pcie_msi_rr_arb #(.N(IRQ_COUNT)) u_arb (
    .req (pending_q),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    msi_int_d  = '0;
    clr        = '0;
    requeue    = '0;
    sent_cnt_d = sent_cnt_q;
    fail_cnt_d = fail_cnt_q;
    to_cnt_d   = to_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_interrupt_msi_enable[0] && gnt.vld) begin
          state_d   = ISSUE;
          cur_d     = gnt.idx;
          clr       = REQ_ONE << gnt.idx;
          ptr_d     = (gnt.idx == LAST_IDX) ? '0 : gnt.idx + 1'b1;
          // Folding only shapes the pulse; pending stays indexed by the source vector.
          msi_int_d = MSI_ONE << (gnt.idx & fold_mask(cfg_interrupt_msi_mmenable[2:0]));
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_ONE;
      end
      WAIT: begin
        if (cfg_interrupt_msi_fail) begin
          requeue    = REQ_ONE << cur_q;
          fail_cnt_d = sat_inc(fail_cnt_q);
          state_d    = BACKOFF;
          cnt_d      = CNT_ONE;
        end else if (cfg_interrupt_msi_sent) begin
          sent_cnt_d = sat_inc(sent_cnt_q);
          state_d    = IDLE;
        end else if (cnt_q == TO_LAST) begin
          requeue  = REQ_ONE << cur_q;
          to_cnt_d = sat_inc(to_cnt_q);
          state_d  = BACKOFF;
          cnt_d    = CNT_ONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BACKOFF: begin
        if (cnt_q == BO_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A set from irq_req or requeue beats the grant's clear on the same bit.
    pending_d = (pending_q & ~clr) | irq_req | requeue;
    pend_de_d = (pending_d != pending_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      pend_de_q  <= 1'b0;
      ptr_q      <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      msi_int_q  <= '0;
      sent_cnt_q <= '0;
      fail_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_de_q  <= pend_de_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      msi_int_q  <= msi_int_d;
      sent_cnt_q <= sent_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Only function 0 is served; the other enable/mmenable fields are don't-care.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  assign irq_pending                                   = pending_q;
  assign cfg_interrupt_msi_int                         = msi_int_q;
  assign cfg_interrupt_msi_pending_status              = 32'(pending_q);
  assign cfg_interrupt_msi_pending_status_data_enable  = pend_de_q;
  assign cfg_interrupt_msi_pending_status_function_num = '0;
  assign cfg_interrupt_msi_select                      = '0;
  assign cfg_interrupt_msi_function_number             = '0;
  assign cfg_interrupt_msi_attr                        = '0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = '0;
  assign cfg_interrupt_msi_tph_st_tag                  = '0;
  assign stat_sent                                     = sent_cnt_q;
  assign stat_fail                                     = fail_cnt_q;
  assign stat_timeout                                  = to_cnt_q;
endmodule
